button_conditioner: RTL



---
 rtl/button_conditioner.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: four-button front end. Synchronizes the raw levels,
// debounces each one, arbitrates new presses by priority (up > down > left > right)
// and optionally repeats the owning button's pulse while it stays held.
// Outputs are registered single-cycle pulses; at most one is high per cycle.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic       up_p,
  output logic       down_p,
  output logic       left_p,
  output logic       right_p,
  output logic [3:0] held,
  output logic       busy
);

  // Repeat runs only when both the delay and the period are configured.
  localparam logic             REPEAT_EN = (REPEAT_DELAY != 0) && (REPEAT_PERIOD != 0);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  // The repeat counter counts down to zero, so loads are one less than the gap.
  localparam logic [CNT_W-1:0] RD_LOAD   = REPEAT_EN ? CNT_W'(REPEAT_DELAY - 1) : '0;
  localparam logic [CNT_W-1:0] RP_LOAD   = REPEAT_EN ? CNT_W'(REPEAT_PERIOD - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } state_t;

  // Bit order everywhere: {up, down, left, right}.
  logic [3:0]       raw_w;
  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  logic [CNT_W-1:0] db_cnt_q [4];
  logic [CNT_W-1:0] db_cnt_d [4];
  logic [3:0]       held_q;
  logic [3:0]       held_d;
  logic [3:0]       first_w;
  state_t           state_q;
  state_t           state_d;
  logic [3:0]       owner_q;
  logic [3:0]       owner_d;
  logic [CNT_W-1:0] rep_cnt_q;
  logic [CNT_W-1:0] rep_cnt_d;
  logic [3:0]       pulse_q;
  logic [3:0]       pulse_d;

  assign raw_w = {up, down, left, right};

  // Two-flop synchronizer per button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_w;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    held_d = held_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == held_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        held_d[i]   = ~held_q[i];
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] != CNT_MAX) begin
        db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Debounce counters and debounced levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
      held_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
      held_q <= held_d;
    end
  end

  // Fixed-priority pick of the highest held button.
  always_comb begin
    first_w = '0;
    if (held_q[3])      first_w = 4'b1000;
    else if (held_q[2]) first_w = 4'b0100;
    else if (held_q[1]) first_w = 4'b0010;
    else if (held_q[0]) first_w = 4'b0001;
  end

  // FSM next state: one pulse per press, then repeats for the owner only.
  // Once the owner lets go, ownership is dropped so no further repeats occur
  // until every button is released and the FSM returns to IDLE.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rep_cnt_d = rep_cnt_q;
    pulse_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (held_q != '0) begin
          pulse_d   = first_w;
          owner_d   = first_w;
          rep_cnt_d = RD_LOAD;
          state_d   = S_HELD;
        end
      end
      S_HELD: begin
        if (held_q == '0) begin
          state_d = S_IDLE;
          owner_d = '0;
        end else if ((owner_q & held_q) == '0) begin
          owner_d = '0;
        end else if (REPEAT_EN) begin
          if (rep_cnt_q == '0) begin
            pulse_d   = owner_q;
            rep_cnt_d = RP_LOAD;
          end else begin
            rep_cnt_d = rep_cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, owner, repeat counter and registered pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      rep_cnt_q <= '0;
      pulse_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rep_cnt_q <= rep_cnt_d;
      pulse_q   <= pulse_d;
    end
  end

  assign up_p    = pulse_q[3];
  assign down_p  = pulse_q[2];
  assign left_p  = pulse_q[1];
  assign right_p = pulse_q[0];
  assign held    = held_q;
  assign busy    = (state_q == S_HELD);

endmodule
